// File: rtl/decode_dispatch_queue.sv
// Decode stage: buffers {pc, inst} from fetch in a small FIFO, decodes the head and dispatches to ROB/RS/LSB.
// Optional macro DEC_ILLEGAL_TRAP_EN: illegal heads dispatch to the ROB only, flagged on to_rob_illegal.
module decode_dispatch_queue #(
  parameter int ROB_WIDTH   = 4,
  parameter int QUEUE_WIDTH = 2,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   clear,
  input  logic                   if_valid,
  input  logic [31:0]            if_pc,
  input  logic [31:0]            if_inst,
  output logic                   if_ready,
  input  logic                   rob_free,
  input  logic                   rs_free,
  input  logic                   lsb_free,
  output logic                   to_rs,
  output logic [5:0]             to_rs_op,
  output logic [4:0]             to_rs_rd,
  output logic [4:0]             to_rs_rs1,
  output logic [4:0]             to_rs_rs2,
  output logic [31:0]            to_rs_imm,
  output logic [31:0]            to_rs_pc,
  output logic [ROB_WIDTH-1:0]   to_rs_tag,
  output logic                   to_lsb,
  output logic [ROB_WIDTH-1:0]   to_lsb_tag,
  output logic                   to_rob,
`ifdef DEC_ILLEGAL_TRAP_EN
  output logic                   to_rob_illegal,
`endif
  output logic [QUEUE_WIDTH:0]   dec_count
);

  logic [QUEUE_WIDTH-1:0] head_reg, tail_reg;
  logic [QUEUE_WIDTH:0]   count_reg;
  logic [ROB_WIDTH-1:0]   tag_cnt_reg, tag_reg;
  logic                   rs_valid_reg, rob_valid_reg, lsb_valid_reg, illegal_reg;
  logic [5:0]             op_reg;
  logic [4:0]             rd_reg, rs1_reg, rs2_reg;
  logic [31:0]            imm_reg, pc_reg;

  logic [31:0] slot_pc   [QUEUE_DEPTH];
  logic [31:0] slot_inst [QUEUE_DEPTH];

  logic full, empty, enq, can_go, disp_legal, disp_ill, pop;

  assign full  = (count_reg == (QUEUE_WIDTH+1)'(QUEUE_DEPTH));
  assign empty = (count_reg == '0);
  assign enq   = if_valid & !full & rdy_in & !clear;

  // Storage slots carry no reset; only pointers and count define validity.
  generate
    for (genvar gi = 0; gi < QUEUE_DEPTH; gi++) begin : g_slot
      logic [31:0] pc_q, inst_q;
      always_ff @(posedge clk_in) begin
        if (enq && tail_reg == QUEUE_WIDTH'(gi)) begin
          pc_q   <= if_pc;
          inst_q <= if_inst;
        end
      end
      assign slot_pc[gi]   = pc_q;
      assign slot_inst[gi] = inst_q;
    end
  endgenerate

  logic [31:0] head_inst, head_pc;
  assign head_inst = slot_inst[head_reg];
  assign head_pc   = slot_pc[head_reg];

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic        f7_zero, f7_alt;
  logic [31:0] imm_i, imm_sh, imm_s, imm_b, imm_j, imm_u;
  assign opcode  = head_inst[6:0];
  assign funct3  = head_inst[14:12];
  assign funct7  = head_inst[31:25];
  assign f7_zero = (funct7 == 7'h00);
  assign f7_alt  = (funct7 == 7'h20);
  assign imm_i   = {{20{head_inst[31]}}, head_inst[31:20]};
  assign imm_sh  = {27'b0, head_inst[24:20]};
  assign imm_s   = {{20{head_inst[31]}}, head_inst[31:25], head_inst[11:7]};
  assign imm_b   = {{19{head_inst[31]}}, head_inst[31], head_inst[7], head_inst[30:25], head_inst[11:8], 1'b0};
  assign imm_j   = {{11{head_inst[31]}}, head_inst[31], head_inst[19:12], head_inst[20], head_inst[30:21], 1'b0};
  assign imm_u   = {head_inst[31:12], 12'b0};

  logic [5:0]  dec_op;
  logic [31:0] dec_imm;
  logic        dec_legal, dec_mem;

  always_comb begin
    dec_op    = '0;
    dec_imm   = '0;
    dec_legal = 1'b0;
    dec_mem   = 1'b0;
    case (opcode)
      7'h33: begin
        dec_legal = f7_zero | (f7_alt & (funct3 == 3'd0 || funct3 == 3'd5));
        case (funct3)
          3'd0:    dec_op = f7_alt ? 6'h01 : 6'h00;
          3'd1:    dec_op = 6'h02;
          3'd2:    dec_op = 6'h03;
          3'd3:    dec_op = 6'h04;
          3'd4:    dec_op = 6'h05;
          3'd5:    dec_op = f7_alt ? 6'h07 : 6'h06;
          3'd6:    dec_op = 6'h08;
          default: dec_op = 6'h09;
        endcase
      end
      7'h13: begin
        dec_legal = 1'b1;
        dec_imm   = imm_i;
        case (funct3)
          3'd0: dec_op = 6'h0A;
          3'd2: dec_op = 6'h0B;
          3'd3: dec_op = 6'h0C;
          3'd4: dec_op = 6'h0D;
          3'd6: dec_op = 6'h0E;
          3'd7: dec_op = 6'h0F;
          3'd1: begin
            dec_op    = 6'h10;
            dec_imm   = imm_sh;
            dec_legal = f7_zero;
          end
          default: begin
            dec_op    = f7_alt ? 6'h12 : 6'h11;
            dec_imm   = imm_sh;
            dec_legal = f7_zero | f7_alt;
          end
        endcase
      end
      7'h03: begin
        dec_imm = imm_i;
        dec_mem = 1'b1;
        case (funct3)
          3'd0:    begin dec_op = 6'h13; dec_legal = 1'b1; end
          3'd1:    begin dec_op = 6'h14; dec_legal = 1'b1; end
          3'd2:    begin dec_op = 6'h15; dec_legal = 1'b1; end
          3'd4:    begin dec_op = 6'h16; dec_legal = 1'b1; end
          3'd5:    begin dec_op = 6'h17; dec_legal = 1'b1; end
          default: ;
        endcase
      end
      7'h23: begin
        dec_imm = imm_s;
        dec_mem = 1'b1;
        case (funct3)
          3'd0:    begin dec_op = 6'h18; dec_legal = 1'b1; end
          3'd1:    begin dec_op = 6'h19; dec_legal = 1'b1; end
          3'd2:    begin dec_op = 6'h1A; dec_legal = 1'b1; end
          default: ;
        endcase
      end
      7'h63: begin
        dec_imm = imm_b;
        case (funct3)
          3'd0:    begin dec_op = 6'h1B; dec_legal = 1'b1; end
          3'd1:    begin dec_op = 6'h1C; dec_legal = 1'b1; end
          3'd4:    begin dec_op = 6'h1D; dec_legal = 1'b1; end
          3'd5:    begin dec_op = 6'h1E; dec_legal = 1'b1; end
          3'd6:    begin dec_op = 6'h1F; dec_legal = 1'b1; end
          3'd7:    begin dec_op = 6'h20; dec_legal = 1'b1; end
          default: ;
        endcase
      end
      7'h6F: begin dec_op = 6'h21; dec_imm = imm_j; dec_legal = 1'b1; end
      7'h67: begin dec_op = 6'h22; dec_imm = imm_i; dec_legal = (funct3 == 3'd0); end
      7'h17: begin dec_op = 6'h23; dec_imm = imm_u; dec_legal = 1'b1; end
      7'h37: begin dec_op = 6'h24; dec_imm = imm_u; dec_legal = 1'b1; end
      default: ;
    endcase
  end

  assign can_go     = rdy_in & !clear & !empty;
  assign disp_legal = can_go & dec_legal & rob_free & rs_free & (!dec_mem | lsb_free);
`ifdef DEC_ILLEGAL_TRAP_EN
  assign disp_ill   = can_go & !dec_legal & rob_free;
  assign pop        = disp_legal | disp_ill;
`else
  // Illegal heads are discarded regardless of downstream free flags.
  assign disp_ill   = 1'b0;
  assign pop        = disp_legal | (can_go & !dec_legal);
`endif

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head_reg      <= '0;
      tail_reg      <= '0;
      count_reg     <= '0;
      tag_cnt_reg   <= '0;
      tag_reg       <= '0;
      rs_valid_reg  <= 1'b0;
      rob_valid_reg <= 1'b0;
      lsb_valid_reg <= 1'b0;
      illegal_reg   <= 1'b0;
      op_reg        <= '0;
      rd_reg        <= '0;
      rs1_reg       <= '0;
      rs2_reg       <= '0;
      imm_reg       <= '0;
      pc_reg        <= '0;
    end else if (rdy_in) begin
      if (clear) begin
        head_reg      <= '0;
        tail_reg      <= '0;
        count_reg     <= '0;
        tag_cnt_reg   <= '0;
        rs_valid_reg  <= 1'b0;
        rob_valid_reg <= 1'b0;
        lsb_valid_reg <= 1'b0;
        illegal_reg   <= 1'b0;
      end else begin
        if (enq) tail_reg <= tail_reg + 1'b1;
        if (pop) head_reg <= head_reg + 1'b1;
        if (enq && !pop)      count_reg <= count_reg + 1'b1;
        else if (!enq && pop) count_reg <= count_reg - 1'b1;
        rs_valid_reg  <= disp_legal;
        rob_valid_reg <= disp_legal | disp_ill;
        lsb_valid_reg <= disp_legal & dec_mem;
        illegal_reg   <= disp_ill;
        if (disp_legal || disp_ill) begin
          op_reg      <= disp_legal ? dec_op : 6'h00;
          imm_reg     <= disp_legal ? dec_imm : 32'h0;
          rd_reg      <= head_inst[11:7];
          rs1_reg     <= head_inst[19:15];
          rs2_reg     <= head_inst[24:20];
          pc_reg      <= head_pc;
          tag_reg     <= tag_cnt_reg;
          tag_cnt_reg <= tag_cnt_reg + 1'b1;
        end
      end
    end
  end

  assign if_ready   = !full;
  assign dec_count  = count_reg;
  assign to_rs      = rs_valid_reg;
  assign to_rob     = rob_valid_reg;
  assign to_lsb     = lsb_valid_reg;
  assign to_rs_op   = op_reg;
  assign to_rs_rd   = rd_reg;
  assign to_rs_rs1  = rs1_reg;
  assign to_rs_rs2  = rs2_reg;
  assign to_rs_imm  = imm_reg;
  assign to_rs_pc   = pc_reg;
  assign to_rs_tag  = tag_reg;
  assign to_lsb_tag = tag_reg;
`ifdef DEC_ILLEGAL_TRAP_EN
  assign to_rob_illegal = illegal_reg;
`else
  logic unused_ok;
  assign unused_ok = illegal_reg;
`endif

endmodule

// File: tb/tb_decode_dispatch_queue.sv
// Testbench for decode_dispatch_queue: decode vector table, directed corner sequences, random run vs queue model.
// Honours DEC_ILLEGAL_TRAP_EN when defined.
module tb_decode_dispatch_queue;
  localparam int ROBW  = 4;
  localparam int QW    = 2;
  localparam int DEPTH = 4;

  logic clk_in = 1'b0;
  logic rst_in, rdy_in, clear, if_valid, if_ready;
  logic [31:0] if_pc, if_inst;
  logic rob_free, rs_free, lsb_free;
  logic to_rs, to_lsb, to_rob;
  logic [5:0] to_rs_op;
  logic [4:0] to_rs_rd, to_rs_rs1, to_rs_rs2;
  logic [31:0] to_rs_imm, to_rs_pc;
  logic [ROBW-1:0] to_rs_tag, to_lsb_tag;
  logic [QW:0] dec_count;
`ifdef DEC_ILLEGAL_TRAP_EN
  logic to_rob_illegal;
`endif

  decode_dispatch_queue #(.ROB_WIDTH(ROBW), .QUEUE_WIDTH(QW), .QUEUE_DEPTH(DEPTH)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .if_ready(if_ready),
    .rob_free(rob_free), .rs_free(rs_free), .lsb_free(lsb_free),
    .to_rs(to_rs), .to_rs_op(to_rs_op), .to_rs_rd(to_rs_rd), .to_rs_rs1(to_rs_rs1),
    .to_rs_rs2(to_rs_rs2), .to_rs_imm(to_rs_imm), .to_rs_pc(to_rs_pc), .to_rs_tag(to_rs_tag),
    .to_lsb(to_lsb), .to_lsb_tag(to_lsb_tag), .to_rob(to_rob),
`ifdef DEC_ILLEGAL_TRAP_EN
    .to_rob_illegal(to_rob_illegal),
`endif
    .dec_count(dec_count)
  );

  always #5 clk_in = ~clk_in;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act !== req) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    else n_pass++;
  endtask

  // Reference decoder: one row per instruction, matched on opcode/funct3/funct7.
  typedef enum {F_R, F_I, F_SH, F_S, F_B, F_J, F_U} fmt_t;
  typedef struct {
    logic [6:0] opc; logic [2:0] f3; bit use_f3; logic [6:0] f7; bit use_f7;
    logic [5:0] op; fmt_t fmt;
  } drow_t;
  drow_t dtab[37];

  task automatic fill_dtab();
    dtab[0]  = '{7'h33,3'd0,1,7'h00,1,6'h00,F_R};  dtab[1]  = '{7'h33,3'd0,1,7'h20,1,6'h01,F_R};
    dtab[2]  = '{7'h33,3'd1,1,7'h00,1,6'h02,F_R};  dtab[3]  = '{7'h33,3'd2,1,7'h00,1,6'h03,F_R};
    dtab[4]  = '{7'h33,3'd3,1,7'h00,1,6'h04,F_R};  dtab[5]  = '{7'h33,3'd4,1,7'h00,1,6'h05,F_R};
    dtab[6]  = '{7'h33,3'd5,1,7'h00,1,6'h06,F_R};  dtab[7]  = '{7'h33,3'd5,1,7'h20,1,6'h07,F_R};
    dtab[8]  = '{7'h33,3'd6,1,7'h00,1,6'h08,F_R};  dtab[9]  = '{7'h33,3'd7,1,7'h00,1,6'h09,F_R};
    dtab[10] = '{7'h13,3'd0,1,7'h00,0,6'h0A,F_I};  dtab[11] = '{7'h13,3'd2,1,7'h00,0,6'h0B,F_I};
    dtab[12] = '{7'h13,3'd3,1,7'h00,0,6'h0C,F_I};  dtab[13] = '{7'h13,3'd4,1,7'h00,0,6'h0D,F_I};
    dtab[14] = '{7'h13,3'd6,1,7'h00,0,6'h0E,F_I};  dtab[15] = '{7'h13,3'd7,1,7'h00,0,6'h0F,F_I};
    dtab[16] = '{7'h13,3'd1,1,7'h00,1,6'h10,F_SH}; dtab[17] = '{7'h13,3'd5,1,7'h00,1,6'h11,F_SH};
    dtab[18] = '{7'h13,3'd5,1,7'h20,1,6'h12,F_SH};
    dtab[19] = '{7'h03,3'd0,1,7'h00,0,6'h13,F_I};  dtab[20] = '{7'h03,3'd1,1,7'h00,0,6'h14,F_I};
    dtab[21] = '{7'h03,3'd2,1,7'h00,0,6'h15,F_I};  dtab[22] = '{7'h03,3'd4,1,7'h00,0,6'h16,F_I};
    dtab[23] = '{7'h03,3'd5,1,7'h00,0,6'h17,F_I};
    dtab[24] = '{7'h23,3'd0,1,7'h00,0,6'h18,F_S};  dtab[25] = '{7'h23,3'd1,1,7'h00,0,6'h19,F_S};
    dtab[26] = '{7'h23,3'd2,1,7'h00,0,6'h1A,F_S};
    dtab[27] = '{7'h63,3'd0,1,7'h00,0,6'h1B,F_B};  dtab[28] = '{7'h63,3'd1,1,7'h00,0,6'h1C,F_B};
    dtab[29] = '{7'h63,3'd4,1,7'h00,0,6'h1D,F_B};  dtab[30] = '{7'h63,3'd5,1,7'h00,0,6'h1E,F_B};
    dtab[31] = '{7'h63,3'd6,1,7'h00,0,6'h1F,F_B};  dtab[32] = '{7'h63,3'd7,1,7'h00,0,6'h20,F_B};
    dtab[33] = '{7'h6F,3'd0,0,7'h00,0,6'h21,F_J};  dtab[34] = '{7'h67,3'd0,1,7'h00,0,6'h22,F_I};
    dtab[35] = '{7'h17,3'd0,0,7'h00,0,6'h23,F_U};  dtab[36] = '{7'h37,3'd0,0,7'h00,0,6'h24,F_U};
  endtask

  function automatic void ref_decode(input logic [31:0] w, output bit legal,
                                     output logic [5:0] op, output logic [31:0] imm, output bit mem);
    legal = 0; op = '0; imm = '0; mem = 0;
    for (int r = 0; r < 37; r++) begin
      if (w[6:0] == dtab[r].opc && (!dtab[r].use_f3 || w[14:12] == dtab[r].f3) &&
          (!dtab[r].use_f7 || w[31:25] == dtab[r].f7)) begin
        legal = 1;
        op    = dtab[r].op;
        mem   = (dtab[r].opc == 7'h03) || (dtab[r].opc == 7'h23);
        case (dtab[r].fmt)
          F_I:  imm = {{20{w[31]}}, w[31:20]};
          F_SH: imm = {27'b0, w[24:20]};
          F_S:  imm = {{20{w[31]}}, w[31:25], w[11:7]};
          F_B:  imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
          F_J:  imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
          F_U:  imm = {w[31:12], 12'b0};
          default: imm = '0;
        endcase
      end
    end
  endfunction

  // Queue model and expected registered outputs.
  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
  ent_t mq[$];
  int m_tag;
  logic e_rs, e_rob, e_lsb, e_ill;
  logic [5:0] e_op;
  logic [4:0] e_rd, e_rs1, e_rs2;
  logic [31:0] e_imm, e_pc;
  logic [ROBW-1:0] e_tag;

  task automatic model_reset();
    mq.delete(); m_tag = 0;
    e_rs = 0; e_rob = 0; e_lsb = 0; e_ill = 0; e_op = '0;
    e_rd = '0; e_rs1 = '0; e_rs2 = '0; e_imm = '0; e_pc = '0; e_tag = '0;
  endtask

  task automatic model_latch(input ent_t e, input logic [5:0] op, input logic [31:0] imm);
    e_op = op; e_imm = imm; e_pc = e.pc;
    e_rd = e.inst[11:7]; e_rs1 = e.inst[19:15]; e_rs2 = e.inst[24:20];
    e_tag = ROBW'(m_tag % (1 << ROBW));
    m_tag++;
  endtask

  task automatic compare_all();
    chk("to_rs", to_rs, e_rs);
    chk("to_rob", to_rob, e_rob);
    chk("to_lsb", to_lsb, e_lsb);
    chk("op", to_rs_op, e_op);
    chk("rd", to_rs_rd, e_rd);
    chk("rs1", to_rs_rs1, e_rs1);
    chk("rs2", to_rs_rs2, e_rs2);
    chk("imm", to_rs_imm, e_imm);
    chk("pc", to_rs_pc, e_pc);
    chk("rs_tag", to_rs_tag, e_tag);
    chk("lsb_tag", to_lsb_tag, e_tag);
    chk("dec_count", dec_count, mq.size());
`ifdef DEC_ILLEGAL_TRAP_EN
    chk("rob_illegal", to_rob_illegal, e_ill);
`endif
  endtask

  // One clock: drive at posedge+1, check if_ready, advance model, compare at next posedge+1.
  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                      input logic rob, input logic rs, input logic lsb, input logic rdy, input logic clr);
    bit was_full, legal, mem;
    logic [5:0] op;
    logic [31:0] imm;
    ent_t h;
    if_valid = v; if_pc = pc; if_inst = inst;
    rob_free = rob; rs_free = rs; lsb_free = lsb; rdy_in = rdy; clear = clr;
    #1;
    chk("if_ready", if_ready, (mq.size() < DEPTH));
    if (rdy) begin
      if (clr) begin
        mq.delete(); m_tag = 0;
        e_rs = 0; e_rob = 0; e_lsb = 0; e_ill = 0;
      end else begin
        was_full = (mq.size() == DEPTH);
        e_rs = 0; e_rob = 0; e_lsb = 0; e_ill = 0;
        if (mq.size() > 0) begin
          h = mq[0];
          ref_decode(h.inst, legal, op, imm, mem);
          if (legal) begin
            if (rob && rs && (!mem || lsb)) begin
              void'(mq.pop_front());
              e_rs = 1; e_rob = 1; e_lsb = mem;
              model_latch(h, op, imm);
            end
          end else begin
`ifdef DEC_ILLEGAL_TRAP_EN
            if (rob) begin
              void'(mq.pop_front());
              e_rob = 1; e_ill = 1;
              model_latch(h, 6'h00, 32'h0);
            end
`else
            void'(mq.pop_front());
`endif
          end
        end
        if (v && !was_full) mq.push_back('{pc, inst});
      end
    end
    @(posedge clk_in);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    #1;
    model_reset();
    compare_all();
    chk("rst_if_ready", if_ready, 1);
    chk("rst_count", dec_count, 0);
    rst_in = 1'b1;
  endtask

  function automatic logic [31:0] rand_inst();
    int s = $urandom_range(0, 9);
    logic [31:0] w = $urandom;
    int r;
    if (s == 0) return 32'h0;
    if (s < 6) begin
      r = $urandom_range(0, 36);
      w[6:0] = dtab[r].opc;
      if (dtab[r].use_f3) w[14:12] = dtab[r].f3;
      if (dtab[r].use_f7) w[31:25] = dtab[r].f7;
    end
    return w;
  endfunction

  typedef struct { logic [31:0] inst; logic [5:0] op; logic [31:0] imm; logic [4:0] rd; logic mem; } vec_t;
  vec_t vecs[12];

  localparam logic [31:0] ADDI_M5 = 32'hFFB00093;
  localparam logic [31:0] SW_8    = 32'h0020A423;

  initial begin
    fill_dtab();
    vecs[0]  = '{32'hFFB00093, 6'h0A, 32'hFFFFFFFB, 5'd1,  1'b0};
    vecs[1]  = '{32'h0020A423, 6'h1A, 32'h00000008, 5'd8,  1'b1};
    vecs[2]  = '{32'h123452B7, 6'h24, 32'h12345000, 5'd5,  1'b0};
    vecs[3]  = '{32'hFFC12183, 6'h15, 32'hFFFFFFFC, 5'd3,  1'b1};
    vecs[4]  = '{32'h40325213, 6'h12, 32'h00000003, 5'd4,  1'b0};
    vecs[5]  = '{32'hFE000CE3, 6'h1B, 32'hFFFFFFF8, 5'd25, 1'b0};
    vecs[6]  = '{32'h010000EF, 6'h21, 32'h00000010, 5'd1,  1'b0};
    vecs[7]  = '{32'h402081B3, 6'h01, 32'h00000000, 5'd3,  1'b0};
    vecs[8]  = '{32'hFFFFF397, 6'h23, 32'hFFFFF000, 5'd7,  1'b0};
    vecs[9]  = '{32'h00008067, 6'h22, 32'h00000000, 5'd0,  1'b0};
    vecs[10] = '{32'h01F09093, 6'h10, 32'h0000001F, 5'd1,  1'b0};
    vecs[11] = '{32'h7FF04103, 6'h16, 32'h000007FF, 5'd2,  1'b1};

    rst_in = 1'b0; rdy_in = 1'b0; clear = 1'b0; if_valid = 1'b0;
    if_pc = '0; if_inst = '0; rob_free = 1'b0; rs_free = 1'b0; lsb_free = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    do_reset();

    // Decode table: enqueue, then dispatch one cycle later.
    for (int i = 0; i < 12; i++) begin
      step(1, 32'h1000 + 32'(i * 4), vecs[i].inst, 1, 1, 1, 1, 0);
      step(0, 32'h0, 32'h0, 1, 1, 1, 1, 0);
      chk("vec_rs", to_rs, 1);
      chk("vec_rob", to_rob, 1);
      chk("vec_lsb", to_lsb, vecs[i].mem);
      chk("vec_op", to_rs_op, vecs[i].op);
      chk("vec_imm", to_rs_imm, vecs[i].imm);
      chk("vec_rd", to_rs_rd, vecs[i].rd);
      chk("vec_pc", to_rs_pc, 32'h1000 + 32'(i * 4));
      chk("vec_tag", to_rs_tag, i);
    end

    // Reset while three entries sit in the queue.
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 32'h500 + 32'(i * 4), ADDI_M5, 0, 1, 1, 1, 0);
    chk("t1_count3", dec_count, 3);
    do_reset();
    step(0, 32'h0, 32'h0, 1, 1, 1, 1, 0);
    chk("t1_no_disp", to_rob, 0);
    step(1, 32'h600, ADDI_M5, 1, 1, 1, 1, 0);
    step(0, 32'h0, 32'h0, 1, 1, 1, 1, 0);
    chk("t1_tag0", to_rs_tag, 0);
    chk("t1_rs", to_rs, 1);

    // Store held while LSB is full.
    do_reset();
    step(1, 32'h700, SW_8, 1, 1, 0, 1, 0);
    step(0, 32'h0, 32'h0, 1, 1, 0, 1, 0);
    chk("t3_stall_rs", to_rs, 0);
    chk("t3_held", dec_count, 1);
    step(0, 32'h0, 32'h0, 1, 1, 1, 1, 0);
    chk("t3_rs", to_rs, 1);
    chk("t3_lsb", to_lsb, 1);
    chk("t3_op", to_rs_op, 6'h1A);
    chk("t3_imm", to_rs_imm, 8);
    step(0, 32'h0, 32'h0, 1, 1, 1, 1, 0);
    chk("t3_pulse_end", to_rs, 0);

    // Fill with ROB busy, ignore fifth, then drain in order.
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 32'h2000 + 32'(i * 4), ADDI_M5, 0, 1, 1, 1, 0);
    chk("t4_full", if_ready, 0);
    step(1, 32'h2010, 32'h123452B7, 0, 1, 1, 1, 0);
    chk("t4_count", dec_count, 4);
    for (int i = 0; i < 4; i++) begin
      step(0, 32'h0, 32'h0, 1, 1, 1, 1, 0);
      chk("t4_tag", to_rs_tag, i);
      chk("t4_pc", to_rs_pc, 32'h2000 + 32'(i * 4));
    end
    chk("t4_empty", dec_count, 0);

    // Hold with rdy_in low right after a dispatch.
    step(1, 32'h2100, ADDI_M5, 1, 1, 1, 1, 0);
    step(0, 32'h0, 32'h0, 1, 1, 1, 1, 0);
    step(1, 32'h2104, ADDI_M5, 1, 1, 1, 0, 0);
    chk("rdy_hold_rs", to_rs, 1);
    chk("rdy_hold_cnt", dec_count, 0);

    // Tag wrap across 17 dispatches, then clear mid-stream.
    do_reset();
    for (int k = 0; k <= 17; k++) begin
      step(k < 17, 32'h3000 + 32'(k * 4), ADDI_M5, 1, 1, 1, 1, 0);
      if (k >= 1) chk("t5_tag", to_rs_tag, (k - 1) % 16);
    end
    step(1, 32'h3100, ADDI_M5, 1, 1, 1, 1, 0);
    step(1, 32'h3104, ADDI_M5, 1, 1, 1, 1, 0);
    step(1, 32'h3108, ADDI_M5, 1, 1, 1, 1, 1);
    chk("t5_clr_count", dec_count, 0);
    chk("t5_clr_rob", to_rob, 0);
    step(1, 32'h310C, ADDI_M5, 1, 1, 1, 1, 0);
    step(0, 32'h0, 32'h0, 1, 1, 1, 1, 0);
    chk("t5_tag_after_clr", to_rs_tag, 0);

    // All-zero word is illegal.
    do_reset();
    step(1, 32'h4000, 32'h0, 1, 1, 1, 1, 0);
    step(0, 32'h0, 32'h0, 1, 1, 1, 1, 0);
    chk("t6_rs", to_rs, 0);
    chk("t6_count", dec_count, 0);
`ifdef DEC_ILLEGAL_TRAP_EN
    chk("t6_rob", to_rob, 1);
    chk("t6_ill", to_rob_illegal, 1);
`else
    chk("t6_rob", to_rob, 0);
`endif
    step(1, 32'h4004, ADDI_M5, 1, 1, 1, 1, 0);
    step(0, 32'h0, 32'h0, 1, 1, 1, 1, 0);
`ifdef DEC_ILLEGAL_TRAP_EN
    chk("t6_next_tag", to_rs_tag, 1);
`else
    chk("t6_next_tag", to_rs_tag, 0);
`endif

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 3) != 0, $urandom, rand_inst(),
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 7) != 0, $urandom_range(0, 49) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
